mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of the RAM and both requester ports.
REQ-002 SHALL have parameter ADDR_W, default 14, RAM word-address width.
REQ-003 SHALL have parameter BURST_MAX, default 4, consecutive CPU grants allowed while DMA waits (legal 1..15).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cpu_req/cpu_we, input, 1 each, CPU access request and write qualifier.
REQ-008 SHALL have ports cpu_addr, input, ADDR_W, and cpu_wdata, input, WIDTH.
REQ-009 SHALL have port cpu_gnt, output, 1, CPU request accepted this cycle.
REQ-010 SHALL have ports cpu_rvalid, output, 1, and cpu_rdata, output, WIDTH, CPU read return.
REQ-011 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid and dma_rdata, with the same directions, widths and meanings as the CPU ports.
REQ-012 SHALL have ports ram_en/ram_we, output, 1 each; ram_addr, output, ADDR_W; ram_wdata, output, WIDTH; ram_rdata, input, WIDTH, from a RAM with 1-cycle registered read.

Function
REQ-013 SHALL transfer a request on any rising edge where req && gnt for that port (valid/ready); gnt SHALL be combinational from req, counter and reset.
REQ-014 SHALL grant at most one port per cycle; gnt SHALL never be high while the matching req is low.
REQ-015 SHALL, for an accepted request at edge N, drive ram_en=1 and ram_we/addr/wdata from that port during cycle N+1; ram_en=0 in all other cycles.
REQ-016 SHALL, for an accepted read, assert the owner's rvalid for exactly one cycle (N+2), with rdata = ram_rdata; writes SHALL produce no rvalid.
REQ-017 SHALL route rdata via a registered owner state with values NONE, CPU and DMA, loaded at each edge from the winner (NONE if no transfer), and delayed one stage for rvalid.
REQ-018 SHALL allow back-to-back transfers from one port on consecutive edges, giving one RAM access per cycle.
REQ-019 SHALL grant the sole requester immediately when only one port requests.
REQ-020 SHALL grant CPU when both ports request, subject to REQ-026.
REQ-021 SHALL hold rvalid of the non-owner port at 0; rdata of a port is don't-care when its rvalid=0.

Reset
REQ-022 SHALL, while reset=0, force asynchronously: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rvalid=dma_rvalid=0, owner=NONE, counter=0.
REQ-023 SHALL hold cpu_gnt=dma_gnt=0 while reset=0.
REQ-024 SHALL discard any in-flight access or read return at reset; no rvalid after reset deasserts unless a new transfer occurs.
REQ-025 SHALL accept a request on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with ARB_STARVE_LIMIT_EN defined, count consecutive CPU grants while dma_req=1; when the count equals BURST_MAX, DMA SHALL win the next contended cycle and the count SHALL clear.
REQ-027 SHALL clear that count whenever dma_req=0 or DMA is granted.
REQ-028 SHALL, with ARB_STARVE_LIMIT_EN undefined, use pure fixed priority (CPU over DMA) with no counter logic synthesized.

Structure
REQ-029 SHALL place the owner-state typedef (NONE/CPU/DMA) and default BURST_MAX constant in shared package mem_arb_pkg.
REQ-030 SHALL isolate the grant decision, including the starvation counter, in sub-module mem_arb_prio; datapath muxing and return routing stay in mem_arbiter.

Verification
REQ-031 SHALL verify: CPU-only read, addr 0x0010, at edge 5 -> ram_en=1 and ram_addr=0x0010 in cycle 6; cpu_rvalid=1 in cycle 7 with cpu_rdata=RAM model word.
REQ-032 SHALL verify: DMA write addr 0x3FFF, data 0xDEADBEEF -> ram_we=1 in the next cycle and no dma_rvalid.
REQ-033 SHALL verify: both requesting continuously, macro defined, BURST_MAX=4 -> grant pattern C,C,C,C,D repeating; macro undefined -> CPU only, dma_gnt never 1.
REQ-034 SHALL verify: CPU back-to-back reads of 0x0001, 0x0002 and 0x0003 on consecutive edges -> three consecutive ram_en cycles and three consecutive rvalid cycles with matching data.
REQ-035 SHALL verify: reset asserted in the cycle ram_en=1 for a CPU read -> ram_en drops immediately and cpu_rvalid stays 0 through and after reset.
REQ-036 SHALL verify: random req stimulus, 10k cycles -> never both gnt high, and every read returns exactly once to its owner.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM bus bundle; the slave modport is the arbiter's view.
interface mem_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [WIDTH-1:0]  cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [WIDTH-1:0]  dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [WIDTH-1:0]  dma_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant decision: CPU over DMA; with ARB_STARVE_LIMIT_EN, DMA wins after BURST_MAX
// consecutive CPU grants it had to wait through.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    output logic cpu_gnt,
    output logic dma_gnt
);

`ifdef ARB_STARVE_LIMIT_EN
    logic [CNT_W-1:0] cnt_p0;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dma_turn;

    assign dma_turn = (cnt_p0 == CNT_W'(BURST_MAX));

    always_comb begin
        cpu_gnt = reset && cpu_req && !(dma_req && dma_turn);
        dma_gnt = reset && dma_req && !cpu_gnt;
        cnt_nxt = cnt_p0;
        if (!dma_req || dma_gnt)
            cnt_nxt = '0;
        else if (cpu_gnt)
            cnt_nxt = cnt_p0 + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_p0 <= '0;
        else
            cnt_p0 <= cnt_nxt;
    end
`else
    assign cpu_gnt = reset && cpu_req;
    assign dma_gnt = reset && dma_req && !cpu_req;

    // Fixed priority keeps no state, so clk and BURST_MAX are deliberately left dangling.
    logic unused_cfg;
    assign unused_cfg = clk ^ (BURST_MAX != 0);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single 1-cycle-read RAM.
// Define ARB_STARVE_LIMIT_EN to bound how long DMA can be starved by CPU.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 14,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    logic              cpu_gnt;
    logic              dma_gnt;
    owner_t            owner_p0;
    owner_t            owner_p1;
    owner_t            owner_nxt;
    owner_t            ret_nxt;
    logic              en_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [WIDTH-1:0]  wdata_p0;

    mem_arb_prio #(
        .BURST_MAX (BURST_MAX)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (bus.cpu_req),
        .dma_req (bus.dma_req),
        .cpu_gnt (cpu_gnt),
        .dma_gnt (dma_gnt)
    );

    assign bus.cpu_gnt = cpu_gnt;
    assign bus.dma_gnt = dma_gnt;

    always_comb begin
        owner_nxt = NONE;
        if (cpu_gnt)
            owner_nxt = CPU;
        else if (dma_gnt)
            owner_nxt = DMA;
        // Writes return nothing, so only reads carry ownership into the return stage.
        ret_nxt = we_p0 ? NONE : owner_p0;
    end

    // Stage p0: RAM access for the transfer accepted at the previous edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_p0 <= NONE;
            owner_p1 <= NONE;
            en_p0    <= 1'b0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else begin
            owner_p0 <= owner_nxt;
            owner_p1 <= ret_nxt;
            en_p0    <= cpu_gnt || dma_gnt;
            we_p0    <= 1'b0;
            if (cpu_gnt) begin
                we_p0    <= bus.cpu_we;
                addr_p0  <= bus.cpu_addr;
                wdata_p0 <= bus.cpu_wdata;
            end else if (dma_gnt) begin
                we_p0    <= bus.dma_we;
                addr_p0  <= bus.dma_addr;
                wdata_p0 <= bus.dma_wdata;
            end
        end
    end

    assign bus.ram_en    = en_p0;
    assign bus.ram_we    = we_p0;
    assign bus.ram_addr  = addr_p0;
    assign bus.ram_wdata = wdata_p0;

    // Stage p1: RAM read data is valid; steer rvalid to the recorded owner
    assign bus.cpu_rvalid = (owner_p1 == CPU);
    assign bus.dma_rvalid = (owner_p1 == DMA);
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.dma_rdata  = bus.ram_rdata;

endmodule
